branch_predictor: RTL

Fetch-side branch target buffer and direction predictor, the front end of the redirect path whose resolution side produces `PcSel`/`BrPC` in EX. At IF it looks up the fetch PC in a direct-mapped table of 2-bit saturating counters and supplies a predicted next PC. At EX it compares the carried prediction against the resolved outcome, raises `mispredict` with the correct `redirect_pc`, and trains the table. It also maintains two 16-bit performance counters.

---
 rtl/branch_predictor.sv | 126 ++++++++++++
 1 files changed

// File: rtl/branch_predictor.sv
// rtl/branch_predictor.sv - direct-mapped BTB with 2-bit direction counters and EX-side mispredict/training
module branch_predictor #(
    parameter int PC_W    = 9,
    parameter int ENTRIES = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [PC_W-1:0] if_pc,
    output logic            pred_taken,
    output logic [31:0]     pred_target,
    input  logic            ex_valid,
    input  logic [PC_W-1:0] ex_pc,
    input  logic            ex_jump,
    input  logic            ex_jump_reg,
    input  logic            ex_pc_sel,
    input  logic [31:0]     ex_br_pc,
    input  logic            ex_pred_taken,
    input  logic [31:0]     ex_pred_target,
    output logic            mispredict,
    output logic [31:0]     redirect_pc,
    output logic [15:0]     ctl_count,
    output logic [15:0]     mispred_count
);
    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = PC_W - IDX_W - 2;

    logic [ENTRIES-1:0] valid_q;
    logic [TAG_W-1:0]   tag_q [ENTRIES];
    logic [PC_W-1:0]    tgt_q [ENTRIES];
    logic [1:0]         ctr_q [ENTRIES];

    logic [IDX_W-1:0] if_idx, ex_idx;
    logic [TAG_W-1:0] if_tag, ex_tag;
    logic             if_hit, ex_hit;

    assign if_idx = if_pc[IDX_W+1:2];
    assign if_tag = if_pc[PC_W-1:IDX_W+2];
    assign ex_idx = ex_pc[IDX_W+1:2];
    assign ex_tag = ex_pc[PC_W-1:IDX_W+2];

    assign if_hit = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
    assign ex_hit = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);

    // Lookup reads the registered table, so a same-cycle training write is not seen.
    assign pred_taken  = reset && if_hit && ctr_q[if_idx][1];
    assign pred_target = pred_taken ? {{(32-PC_W){1'b0}}, tgt_q[if_idx]}
                                    : {{(32-PC_W){1'b0}}, if_pc} + 32'd4;

    logic dir_wrong, tgt_wrong;
    assign dir_wrong   = ex_pc_sel != ex_pred_taken;
    assign tgt_wrong   = ex_pc_sel && ex_pred_taken && (ex_br_pc != ex_pred_target);
    assign mispredict  = reset && ex_valid && (dir_wrong || tgt_wrong);
    assign redirect_pc = ex_pc_sel ? ex_br_pc : {{(32-PC_W){1'b0}}, ex_pc} + 32'd4;

    logic             wr_en;
    logic             wr_valid;
    logic [TAG_W-1:0] wr_tag;
    logic [PC_W-1:0]  wr_tgt;
    logic [1:0]       wr_ctr;

    always_comb begin
        wr_en    = 1'b0;
        wr_valid = valid_q[ex_idx];
        wr_tag   = tag_q[ex_idx];
        wr_tgt   = tgt_q[ex_idx];
        wr_ctr   = ctr_q[ex_idx];
        if (ex_valid) begin
            if (ex_jump_reg) begin
                // Register-indirect targets are not worth caching; drop any stale entry.
                if (ex_hit) begin
                    wr_en    = 1'b1;
                    wr_valid = 1'b0;
                end
            end else if (ex_jump) begin
                wr_en    = 1'b1;
                wr_valid = 1'b1;
                wr_tag   = ex_tag;
                wr_tgt   = ex_br_pc[PC_W-1:0];
                wr_ctr   = 2'b11;
            end else if (ex_pc_sel) begin
                wr_en    = 1'b1;
                wr_valid = 1'b1;
                wr_tag   = ex_tag;
                wr_tgt   = ex_br_pc[PC_W-1:0];
                if (ex_hit) begin
                    wr_ctr = (ctr_q[ex_idx] == 2'b11) ? 2'b11 : ctr_q[ex_idx] + 2'd1;
                end else begin
                    wr_ctr = 2'b10;
                end
            end else if (ex_hit) begin
                wr_en  = 1'b1;
                wr_ctr = (ctr_q[ex_idx] == 2'b00) ? 2'b00 : ctr_q[ex_idx] - 2'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                tag_q[i] <= '0;
                tgt_q[i] <= '0;
                ctr_q[i] <= 2'b01;
            end
        end else if (wr_en) begin
            valid_q[ex_idx] <= wr_valid;
            tag_q[ex_idx]   <= wr_tag;
            tgt_q[ex_idx]   <= wr_tgt;
            ctr_q[ex_idx]   <= wr_ctr;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ctl_count     <= '0;
            mispred_count <= '0;
        end else if (ex_valid) begin
            if (ctl_count != 16'hFFFF) begin
                ctl_count <= ctl_count + 16'd1;
            end
            if (mispredict && (mispred_count != 16'hFFFF)) begin
                mispred_count <= mispred_count + 16'd1;
            end
        end
    end
endmodule
